// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential reads to a 1-cycle synchronous memory and hands
// bytes to decode over valid/ready. Optional FETCH_WRAP_STOP_EN stops fetching after 0xFF.
module instr_fetch_unit #(
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 8,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic              wrap_err
);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_STOP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0] skid_pc;
  logic              consume;
  logic              issue;
  logic [1:0]        occ;
  logic [1:0]        occ_after;

  assign consume   = instr_valid & instr_ready;
  assign occ       = {1'b0, instr_valid} + {1'b0, skid_valid} + {1'b0, inflight};
  assign occ_after = occ - {1'b0, consume};

`ifdef FETCH_WRAP_STOP_EN
  logic wrap_hit;
  assign wrap_hit = issue & (mem_addr == '1);
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (jump_en || state != S_STOP) state_nxt = halt ? S_HALT : S_RUN;
`ifdef FETCH_WRAP_STOP_EN
    if (wrap_hit) state_nxt = S_STOP;
`endif
  end

  // Output logic. Issue looks at the live halt level rather than the registered S_HALT,
  // so fetching resumes in the same cycle halt drops.
  always_comb begin
    mem_addr = jump_en ? jump_addr : pc;
    if (jump_en) issue = ~halt;
    else         issue = (state != S_STOP) && !halt && (occ_after < 2'd2);
  end

  // Datapath: PC, in-flight tracker, output register and one-entry skid buffer.
  // NOTE: the data/pc registers are reset too, since instr and instr_pc must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_pc     <= '0;
    end else if (jump_en) begin
      instr_valid <= 1'b0;
      skid_valid  <= 1'b0;
      inflight    <= issue;
      inflight_pc <= jump_addr;
      pc          <= issue ? jump_addr + 1'b1 : jump_addr;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + 1'b1;
        inflight_pc <= pc;
      end
      if (!instr_valid || instr_ready) begin
        if (skid_valid) begin
          // Older skid byte goes out first; a returning byte refills the skid.
          instr       <= skid_data;
          instr_pc    <= skid_pc;
          instr_valid <= 1'b1;
          skid_valid  <= inflight;
          if (inflight) begin
            skid_data <= mem_rdata;
            skid_pc   <= inflight_pc;
          end
        end else begin
          instr_valid <= inflight;
          if (inflight) begin
            instr    <= mem_rdata;
            instr_pc <= inflight_pc;
          end
        end
      end else if (inflight) begin
        skid_valid <= 1'b1;
        skid_data  <= mem_rdata;
        skid_pc    <= inflight_pc;
      end
    end
  end

`ifdef FETCH_WRAP_STOP_EN
  always_ff @(posedge clk) begin
    if (rst)           wrap_err <= 1'b0;
    else if (wrap_hit) wrap_err <= 1'b1;
    else if (jump_en)  wrap_err <= 1'b0;
  end
`else
  assign wrap_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal expectations plus a
// stream model (delivered bytes must follow memory along the PC sequence) checked every cycle.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_addr, mem_rdata, instr, instr_pc, jump_addr;
  logic       instr_valid, instr_ready, jump_en, halt, wrap_err;
  logic [7:0] mem_addr2, mem_rdata2, instr2, instr_pc2;
  logic       instr_valid2, wrap_err2;
  logic       one = 1'b1;
  logic       zero = 1'b0;
  logic [7:0] zero8 = 8'h00;

  logic [7:0] mem  [256];
  logic [7:0] mem2 [256];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jump_en(jump_en), .jump_addr(jump_addr), .halt(halt), .wrap_err(wrap_err)
  );

  instr_fetch_unit #(.RESET_VECTOR(8'hFE)) dut2 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2), .instr(instr2),
    .instr_pc(instr_pc2), .instr_valid(instr_valid2), .instr_ready(one),
    .jump_en(zero), .jump_addr(zero8), .halt(zero), .wrap_err(wrap_err2)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories.
  always @(posedge clk) begin
    mem_rdata  <= mem[mem_addr];
    mem_rdata2 <= mem2[mem_addr2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Stream model: every transfer must carry mem[exp_pc] from exp_pc, in order; held bytes stay
  // stable; nothing valid right after a flush; mem_addr frozen while halt stays high.
  logic [7:0] exp_pc = 8'h00;
  logic       prev_flush = 1'b0, prev_hold = 1'b0, prev_halt = 1'b0;
  logic [7:0] prev_instr, prev_ipc, prev_addr;

  always @(negedge clk) begin
    if (prev_flush) check("flush_clears_valid", instr_valid, 0);
    if (prev_hold && !rst) begin
      check("hold_valid", instr_valid, 1);
      check("hold_instr", instr, prev_instr);
      check("hold_pc", instr_pc, prev_ipc);
    end
    if (prev_halt && halt && !jump_en && !rst) check("halt_addr_frozen", mem_addr, prev_addr);
    if (!rst && instr_valid && instr_ready) begin
      check("stream_instr", instr, mem[exp_pc]);
      check("stream_pc", instr_pc, exp_pc);
      exp_pc = exp_pc + 8'd1;
    end
    if (rst)          exp_pc = 8'h00;
    else if (jump_en) exp_pc = jump_addr;
    prev_flush = rst | jump_en;
    prev_hold  = instr_valid & ~instr_ready & ~jump_en & ~rst;
    prev_halt  = halt & ~jump_en & ~rst;
    prev_instr = instr;
    prev_ipc   = instr_pc;
    prev_addr  = mem_addr;
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Pulses reset, checks the reset state, and returns at the start of cycle 0 (rst low).
  task automatic restart();
    rst = 1'b1; jump_en = 1'b0; halt = 1'b0; instr_ready = 1'b1; jump_addr = 8'h00;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_wrap_err", wrap_err, 0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst2_mem_addr", mem_addr2, 8'hFE);
    check("rst2_valid", instr_valid2, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic expect_out(input string name, input logic [7:0] d, input logic [7:0] p);
    check({name, "_valid"}, instr_valid, 1);
    check({name, "_instr"}, instr, d);
    check({name, "_pc"}, instr_pc, p);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i) ^ 8'h5A;
      mem2[i] = 8'(i) ^ 8'h3C;
    end
    mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3;
    mem[8'h40] = 8'hB0; mem[8'h41] = 8'hB1;
    mem2[8'hFE] = 8'hC0; mem2[8'hFF] = 8'hC1; mem2[8'h00] = 8'hC2; mem2[8'h01] = 8'hC3;
    instr_ready = 1'b1; jump_en = 1'b0; halt = 1'b0; jump_addr = 8'h00;

    // Basic latency and back-to-back streaming.
    restart();
    @(negedge clk); check("t1_c0_addr", mem_addr, 8'h00); check("t1_c0_valid", instr_valid, 0);
    goto(1); @(negedge clk); check("t1_c1_addr", mem_addr, 8'h01); check("t1_c1_valid", instr_valid, 0);
    goto(2); @(negedge clk); expect_out("t1_c2", 8'hA0, 8'h00);
    goto(3); @(negedge clk); expect_out("t1_c3", 8'hA1, 8'h01);
    goto(4); @(negedge clk); expect_out("t1_c4", 8'hA2, 8'h02);
    goto(5); @(negedge clk); expect_out("t1_c5", 8'hA3, 8'h03);

    // Back-pressure for 5 cycles from cycle 3.
    restart();
    goto(3); instr_ready = 1'b0; @(negedge clk); expect_out("t2_c3", 8'hA1, 8'h01);
    goto(7); @(negedge clk); expect_out("t2_c7", 8'hA1, 8'h01); check("t2_c7_addr", mem_addr, 8'h03);
    goto(8); instr_ready = 1'b1; @(negedge clk); expect_out("t2_c8", 8'hA1, 8'h01);
    check("t2_c8_addr", mem_addr, 8'h03);
    goto(9); @(negedge clk); expect_out("t2_c9", 8'hA2, 8'h02); check("t2_c9_addr", mem_addr, 8'h04);
    goto(10); @(negedge clk); expect_out("t2_c10", 8'hA3, 8'h03);

    // Jump in cycle 4 to 0x40.
    restart();
    goto(4); jump_en = 1'b1; jump_addr = 8'h40;
    @(negedge clk); check("t3_c4_addr", mem_addr, 8'h40); expect_out("t3_c4", 8'hA2, 8'h02);
    goto(5); jump_en = 1'b0; @(negedge clk); check("t3_c5_valid", instr_valid, 0);
    check("t3_c5_addr", mem_addr, 8'h41);
    goto(6); @(negedge clk); expect_out("t3_c6", 8'hB0, 8'h40);
    goto(7); @(negedge clk); expect_out("t3_c7", 8'hB1, 8'h41);

    // Halt during cycles 3..6.
    restart();
    goto(3); halt = 1'b1; @(negedge clk); check("t4_c3_addr", mem_addr, 8'h03); expect_out("t4_c3", 8'hA1, 8'h01);
    goto(4); @(negedge clk); expect_out("t4_c4", 8'hA2, 8'h02);
    goto(5); @(negedge clk); check("t4_c5_valid", instr_valid, 0);
    goto(6); @(negedge clk); check("t4_c6_addr", mem_addr, 8'h03);
    goto(7); halt = 1'b0; @(negedge clk); check("t4_c7_addr", mem_addr, 8'h03); check("t4_c7_valid", instr_valid, 0);
    goto(8); @(negedge clk); check("t4_c8_addr", mem_addr, 8'h04); check("t4_c8_valid", instr_valid, 0);
    goto(9); @(negedge clk); expect_out("t4_c9", 8'hA3, 8'h03);

    // Reset pulse while a byte is held and another read is in flight.
    restart();
    goto(3); instr_ready = 1'b0; rst = 1'b1; @(negedge clk); expect_out("t5_c3", 8'hA1, 8'h01);
    @(posedge clk); #1; rst = 1'b0; instr_ready = 1'b1; cyc = 0;
    @(negedge clk); check("t5_n0_valid", instr_valid, 0); check("t5_n0_addr", mem_addr, 8'h00);
    goto(1); @(negedge clk); check("t5_n1_valid", instr_valid, 0);
    goto(2); @(negedge clk); expect_out("t5_n2", 8'hA0, 8'h00);
    goto(3); @(negedge clk); expect_out("t5_n3", 8'hA1, 8'h01);

    // Jump while halted: retarget only, issue once halt drops.
    restart();
    goto(3); halt = 1'b1;
    goto(4); jump_en = 1'b1; jump_addr = 8'h40; @(negedge clk); check("t7_c4_addr", mem_addr, 8'h40);
    goto(5); jump_en = 1'b0; @(negedge clk); check("t7_c5_addr", mem_addr, 8'h40);
    goto(6); halt = 1'b0; @(negedge clk); check("t7_c6_addr", mem_addr, 8'h40); check("t7_c6_valid", instr_valid, 0);
    goto(7); @(negedge clk); check("t7_c7_addr", mem_addr, 8'h41); check("t7_c7_valid", instr_valid, 0);
    goto(8); @(negedge clk); expect_out("t7_c8", 8'hB0, 8'h40);

    // PC wrap from RESET_VECTOR 0xFE on the second instance.
    restart();
    goto(1); @(negedge clk); check("t6_c1_wrap", wrap_err2, 0);
    goto(2); @(negedge clk);
    check("t6_c2_valid", instr_valid2, 1); check("t6_c2_instr", instr2, 8'hC0); check("t6_c2_pc", instr_pc2, 8'hFE);
    goto(3); @(negedge clk);
    check("t6_c3_valid", instr_valid2, 1); check("t6_c3_instr", instr2, 8'hC1); check("t6_c3_pc", instr_pc2, 8'hFF);
    goto(4); @(negedge clk);
`ifdef FETCH_WRAP_STOP_EN
    check("t6_c4_valid", instr_valid2, 0); check("t6_c4_wrap", wrap_err2, 1);
`else
    check("t6_c4_valid", instr_valid2, 1); check("t6_c4_instr", instr2, 8'hC2); check("t6_c4_pc", instr_pc2, 8'h00);
`endif
    goto(5); @(negedge clk);
`ifdef FETCH_WRAP_STOP_EN
    check("t6_c5_valid", instr_valid2, 0); check("t6_c5_wrap", wrap_err2, 1);
`else
    check("t6_c5_valid", instr_valid2, 1); check("t6_c5_instr", instr2, 8'hC3); check("t6_c5_pc", instr_pc2, 8'h01);
    check("t6_c5_wrap", wrap_err2, 0);
`endif
    goto(7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
